log_prob_nll_reader: RTL and testbench

Consumer-side block for the log-softmax output stream. It reads one row of N signed Q16.16 log-probabilities per transaction, one element per accepted beat. Per row it reports the argmax index, the maximum log-probability and the negative log-likelihood at a per-row target index. It sits directly downstream of the log-softmax operator and feeds the loss/accuracy reporting logic, adding a ready/valid handshake on both sides.

---
 rtl/log_prob_nll_reader.sv | 136 +++++++++++++
 tb/tb_log_prob_nll_reader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/log_prob_nll_reader.sv
// Row reader for log-softmax output: tracks argmax, max and target NLL per row.
// One element per accepted beat; the result is held until the downstream side takes it.
module log_prob_nll_reader #(
   parameter int N     = 16,
   parameter int IDX_W = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_in,
   output logic             ready_in,
   input  logic [31:0]      input_data,
   input  logic [IDX_W:0]   target_idx,
   output logic             valid_out,
   input  logic             ready_out,
   output logic [IDX_W-1:0] argmax_idx,
   output logic [31:0]      max_data,
   output logic [31:0]      loss_data,
   output logic             err_out
);

   typedef enum logic {ACCUM, HOLD} state_t;

   localparam logic [31:0] SAT_POS = 32'h7FFF_FFFF;
   localparam logic [31:0] MOST_NEG = 32'h8000_0000;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   cnt_q, cnt_d;
   logic signed [31:0] max_q, max_d;
   logic [IDX_W-1:0]   amax_q, amax_d;
   logic [IDX_W:0]     tgt_q, tgt_d;
   logic [31:0]        tval_q, tval_d;
   logic               vld_q, vld_d;
   logic [IDX_W-1:0]   oidx_q, oidx_d;
   logic [31:0]        omax_q, omax_d;
   logic [31:0]        loss_q, loss_d;
   logic               err_q, err_d;

   logic               acc, first, last, tgt_oob;
   logic [IDX_W:0]     tgt_cur;
   logic signed [31:0] rmax;
   logic [IDX_W-1:0]   ridx;
   logic [31:0]        tv_cur;

   // ready_in comes from registered state only; rst gates it during reset
   assign ready_in   = (state_q == ACCUM) && !rst;
   assign acc        = valid_in && ready_in;
   assign valid_out  = vld_q;
   assign argmax_idx = oidx_q;
   assign max_data   = omax_q;
   assign loss_data  = loss_q;
   assign err_out    = err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ACCUM;
         cnt_q   <= '0;
         max_q   <= '0;
         amax_q  <= '0;
         tgt_q   <= '0;
         tval_q  <= '0;
         vld_q   <= 1'b0;
         oidx_q  <= '0;
         omax_q  <= '0;
         loss_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         max_q   <= max_d;
         amax_q  <= amax_d;
         tgt_q   <= tgt_d;
         tval_q  <= tval_d;
         vld_q   <= vld_d;
         oidx_q  <= oidx_d;
         omax_q  <= omax_d;
         loss_q  <= loss_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      max_d   = max_q;
      amax_d  = amax_q;
      tgt_d   = tgt_q;
      tval_d  = tval_q;
      vld_d   = vld_q;
      oidx_d  = oidx_q;
      omax_d  = omax_q;
      loss_d  = loss_q;
      err_d   = err_q;

      first   = (cnt_q == '0);
      last    = (cnt_q == IDX_W'(N - 1));
      tgt_cur = first ? target_idx : tgt_q;
      tgt_oob = (tgt_cur >= (IDX_W + 1)'(N));

      // strict compare: ties keep the earlier index
      if (first || ($signed(input_data) > max_q)) begin
         rmax = $signed(input_data);
         ridx = cnt_q;
      end else begin
         rmax = max_q;
         ridx = amax_q;
      end
      tv_cur = ({1'b0, cnt_q} == tgt_cur) ? input_data : tval_q;

      unique case (state_q)
         ACCUM: begin
            if (acc) begin
               cnt_d  = last ? '0 : cnt_q + IDX_W'(1);
               max_d  = rmax;
               amax_d = ridx;
               tgt_d  = tgt_cur;
               tval_d = tv_cur;
               if (last) begin
                  vld_d   = 1'b1;
                  oidx_d  = ridx;
                  omax_d  = rmax;
                  err_d   = tgt_oob;
                  loss_d  = (tgt_oob || tv_cur == MOST_NEG) ? SAT_POS : 32'(-tv_cur);
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (ready_out) begin
               vld_d   = 1'b0;
               state_d = ACCUM;
            end
         end
      endcase
   end

endmodule

// File: tb/tb_log_prob_nll_reader.sv
// Bench for log_prob_nll_reader (N=4): directed rows with literal results,
// then random rows and backpressure against a row-level reference model.
module tb_log_prob_nll_reader;
   localparam int N  = 4;
   localparam int IW = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          valid_in = 1'b0;
   logic          ready_in;
   logic [31:0]   input_data = '0;
   logic [IW:0]   target_idx = '0;
   logic          valid_out;
   logic          ready_out = 1'b1;
   logic [IW-1:0] argmax_idx;
   logic [31:0]   max_data;
   logic [31:0]   loss_data;
   logic          err_out;

   int n_chk = 0;
   int n_err = 0;

   log_prob_nll_reader #(.N(N), .IDX_W(IW)) dut (
      .clk(clk), .rst(rst),
      .valid_in(valid_in), .ready_in(ready_in),
      .input_data(input_data), .target_idx(target_idx),
      .valid_out(valid_out), .ready_out(ready_out),
      .argmax_idx(argmax_idx), .max_data(max_data),
      .loss_data(loss_data), .err_out(err_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      n_chk++;
      if (a !== e) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
      end
   endtask

   // Reference model: collect accepted elements into a row, then evaluate
   logic [31:0] mrow[$];
   int          mtgt;
   bit          ev = 1'b0;
   int          eidx;
   logic [31:0] emax, eloss;
   bit          eerr;

   always @(negedge clk) begin
      if (rst) begin
         mrow.delete();
         ev = 1'b0;
         chk("rst_valid_out", 32'(valid_out), 32'd0);
         chk("rst_ready_in", 32'(ready_in), 32'd0);
         chk("rst_argmax", 32'(argmax_idx), 32'd0);
         chk("rst_max", max_data, 32'd0);
         chk("rst_loss", loss_data, 32'd0);
         chk("rst_err", 32'(err_out), 32'd0);
      end else begin
         chk("valid_out", 32'(valid_out), 32'(ev));
         chk("ready_in", 32'(ready_in), 32'(!ev));
         if (ev) begin
            chk("argmax_idx", 32'(argmax_idx), 32'(eidx));
            chk("max_data", max_data, emax);
            chk("loss_data", loss_data, eloss);
            chk("err_out", 32'(err_out), 32'(eerr));
         end
         if (ev && ready_out) begin
            ev = 1'b0;
         end else if (!ev && valid_in) begin
            if (mrow.size() == 0) mtgt = int'(target_idx);
            mrow.push_back(input_data);
            if (mrow.size() == N) begin
               eidx = 0;
               for (int i = 1; i < N; i++)
                  if ($signed(mrow[i]) > $signed(mrow[eidx])) eidx = i;
               emax = mrow[eidx];
               eerr = (mtgt >= N);
               if (eerr) eloss = 32'h7FFF_FFFF;
               else if (mrow[mtgt] == 32'h8000_0000) eloss = 32'h7FFF_FFFF;
               else eloss = 32'd0 - mrow[mtgt];
               ev = 1'b1;
               mrow.delete();
            end
         end
      end
   end

   task automatic beat(input bit v, input logic [31:0] d, input logic [IW:0] t,
                       input bit rnd_rdy, output bit acc);
      valid_in   = v;
      input_data = d;
      target_idx = t;
      if (rnd_rdy) ready_out = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = v && ready_in && !rst;
      @(posedge clk);
      #2;
      valid_in = 1'b0;
   endtask

   // mode 0: back-to-back, 1: fixed gap pattern, 2: random gaps
   task automatic send_row(input logic [31:0] d[4], input logic [IW:0] t,
                           input int mode, input bit rnd_rdy);
      int pi;
      int tries;
      bit acc, v;
      bit pat[7];
      logic [IW:0] tt;
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      pi = 0;
      for (int i = 0; i < N; i++) begin
         tries = 0;
         acc = 1'b0;
         while (!acc && tries < 100) begin
            if (mode == 0) v = 1'b1;
            else if (mode == 1) v = pat[pi % 7];
            else v = 1'($urandom_range(0, 1));
            pi++;
            tt = (i == 0) ? t : (IW + 1)'($urandom);
            beat(v, d[i], tt, rnd_rdy, acc);
            tries++;
         end
         if (!acc) begin
            n_chk++;
            n_err++;
            $display("FAIL beat_timeout: element %0d not accepted in 100 cycles", i);
         end
      end
   endtask

   task automatic wait_res(input string nm, input logic [31:0] ei, input logic [31:0] em,
                           input logic [31:0] el, input logic [31:0] ee);
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!valid_out && k < 50);
      if (!valid_out) begin
         n_chk++;
         n_err++;
         $display("FAIL %s_timeout: valid_out=0 required 1 within 50 cycles", nm);
      end else begin
         chk({nm, "_idx"}, 32'(argmax_idx), ei);
         chk({nm, "_max"}, max_data, em);
         chk({nm, "_loss"}, loss_data, el);
         chk({nm, "_err"}, 32'(err_out), ee);
      end
      @(posedge clk);
      #2;
   endtask

   logic [31:0] r1[4], rt[4], re[4], rx[4], rr[4];
   bit          a;

   initial begin
      r1 = '{32'hFFFE_0000, 32'hFFFF_8000, 32'hFFFF_0000, 32'hFFFD_0000};
      rt = '{32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_E000, 32'hFFFF_F000};
      re = '{32'hFFFF_0000, 32'hFFFE_0000, 32'hFFFD_0000, 32'h8000_0000};
      rx = '{32'h0000_0100, 32'h0000_0500, 32'hFFFF_FD00, 32'h0000_0200};

      repeat (2) @(posedge clk);
      #2;
      chk("init_ready_in", 32'(ready_in), 32'd0);
      chk("init_valid_out", 32'(valid_out), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #2;

      send_row(r1, 3'd2, 0, 1'b0);
      wait_res("basic", 32'd1, 32'hFFFF_8000, 32'h0001_0000, 32'd0);
      chk("basic_pulse", 32'(valid_out), 32'd0);

      send_row(rt, 3'd0, 0, 1'b0);
      wait_res("tie", 32'd0, 32'hFFFF_F000, 32'h0000_1000, 32'd0);

      send_row(r1, 3'd2, 1, 1'b0);
      wait_res("gap", 32'd1, 32'hFFFF_8000, 32'h0001_0000, 32'd0);

      ready_out = 1'b0;
      send_row(rt, 3'd0, 0, 1'b0);
      wait_res("bp", 32'd0, 32'hFFFF_F000, 32'h0000_1000, 32'd0);
      repeat (5) begin
         valid_in   = 1'b1;
         input_data = 32'h1234_5678;
         @(negedge clk);
         chk("bp_ready_in", 32'(ready_in), 32'd0);
         chk("bp_loss", loss_data, 32'h0000_1000);
         @(posedge clk);
         #2;
      end
      valid_in  = 1'b0;
      ready_out = 1'b1;
      @(posedge clk);
      #2;
      chk("bp_release_ready", 32'(ready_in), 32'd1);

      send_row(re, 3'd3, 0, 1'b0);
      wait_res("sat", 32'd0, 32'hFFFF_0000, 32'h7FFF_FFFF, 32'd0);

      send_row(rx, 3'd5, 0, 1'b0);
      wait_res("oob", 32'd1, 32'h0000_0500, 32'h7FFF_FFFF, 32'd1);

      beat(1'b1, 32'h7FFF_0000, 3'd1, 1'b0, a);
      beat(1'b1, 32'h7FFF_0000, 3'd1, 1'b0, a);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_ready", 32'(ready_in), 32'd0);
      chk("mid_rst_max", max_data, 32'd0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      @(posedge clk);
      #2;
      send_row(r1, 3'd2, 0, 1'b0);
      wait_res("post_rst", 32'd1, 32'hFFFF_8000, 32'h0001_0000, 32'd0);

      for (int n = 0; n < 40; n++) begin
         for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 3))
               0: rr[i] = 32'h8000_0000;
               1: rr[i] = 32'hFFFF_0000 - 32'($urandom_range(0, 2));
               default: rr[i] = $urandom;
            endcase
         end
         send_row(rr, (IW + 1)'($urandom_range(0, 7)), 2, 1'b1);
      end
      ready_out = 1'b1;
      repeat (10) @(posedge clk);
      #2;
      chk("drain_valid_out", 32'(valid_out), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
